// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Sequencer and two-way arbiter for the Altair synchronous memory bus. It
// generates the i8080 clock enable (cpu_ce) itself and, between CPU bus slots,
// lends the memory bus to a DMA-style loader/debug port. The CPU sees every
// DMA transfer as a stretched clock: cpu_ce stays low, so its bus cycle is
// simply re-presented afterwards.
//
// Slot structure:
//   CPU slot : CPU_A (write strobe live) -> CPU_B (cpu_ce=1, arbitration)
//   DMA slot : DMA_ACC (strobe) -> DMA_DONE (ack, read capture) -> DMA_WAIT
//              (arbitration)
// After DMA_BURST back-to-back DMA transfers one CPU slot is forced.
//
// Parameters
//   DMA_BURST  maximum consecutive DMA transfers before a CPU slot (>= 1)
//
// Ports
//   clk        system clock
//   reset      asynchronous reset, active low (0 = reset)
//   cpu_addr   CPU address                  cpu_odata  CPU write data
//   cpu_rd     CPU read strobe              cpu_wr_n   CPU write strobe (low)
//   cpu_ce     CPU clock enable
//   dma_req    DMA request level            dma_we     1 = write, 0 = read
//   dma_addr   DMA address                  dma_wdata  DMA write data
//   dma_ack    one-cycle transfer-complete pulse
//   dma_rdata  read data, valid from the dma_ack cycle, held until next read
//   dma_grant  DMA owns the bus (top level forces memory decode)
//   mem_addr   bus address                  mem_wdata  bus write data
//   mem_rd     bus read strobe              mem_we     bus write strobe
//   mem_rdata  decoded read data, valid one cycle after mem_rd
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int DMA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rd,
  input  logic        cpu_wr_n,
  output logic        cpu_ce,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        dma_grant,

  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  // Burst counter must be able to hold the value DMA_BURST itself.
  localparam int            BCNT_W    = $clog2(DMA_BURST + 1);
  localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(DMA_BURST);

  typedef enum logic [2:0] {
    CPU_A,
    CPU_B,
    DMA_ACC,
    DMA_DONE,
    DMA_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q,  bcnt_d;
  logic [7:0]          rdata_q, rdata_d;

  // Raw bus strobes before reset qualification.
  logic                bus_rd;
  logic                bus_we;

  // ---------------------------------------------------------------------------
  // State, burst counter and read-data holding register.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CPU_A;
      bcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      rdata_q <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and bus steering.
  // cpu_ce, dma_grant and dma_ack depend on state_q only, so they cannot
  // glitch with the asynchronous CPU/DMA inputs.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    rdata_d   = rdata_q;

    cpu_ce    = 1'b0;
    dma_grant = 1'b0;
    dma_ack   = 1'b0;
    dma_rdata = rdata_q;

    mem_addr  = cpu_addr;
    mem_wdata = cpu_odata;
    bus_rd    = 1'b0;
    bus_we    = 1'b0;

    unique case (state_q)
      CPU_A: begin
        bus_rd  = cpu_rd;
        bus_we  = ~cpu_wr_n;
        state_d = CPU_B;
      end

      CPU_B: begin
        // Write strobe suppressed here so a CPU write lands exactly once
        // per slot even though the CPU holds wr_n low across both cycles.
        bus_rd  = cpu_rd;
        cpu_ce  = 1'b1;
        bcnt_d  = '0;
        state_d = dma_req ? DMA_ACC : CPU_A;
      end

      DMA_ACC: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        bus_we    = dma_we;
        bus_rd    = ~dma_we;
        dma_grant = 1'b1;
        state_d   = DMA_DONE;
      end

      DMA_DONE: begin
        // Memory returns read data this cycle; forward it combinationally
        // so dma_rdata is valid alongside dma_ack, and latch it for later.
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_grant = 1'b1;
        dma_ack   = 1'b1;
        bcnt_d    = bcnt_q + 1'b1;
        if (!dma_we) begin
          rdata_d   = mem_rdata;
          dma_rdata = mem_rdata;
        end
        state_d   = DMA_WAIT;
      end

      DMA_WAIT: begin
        // Bus returns to the CPU address with no strobes; the CPU is still
        // frozen, so CPU_A re-presents its pending cycle.
        state_d = (dma_req && (bcnt_q < BURST_MAX)) ? DMA_ACC : CPU_A;
      end

      default: begin
        state_d = CPU_A;
      end
    endcase
  end

  // NOTE: strobes are qualified with reset combinationally so they drop the
  // instant reset asserts, not at the next clock edge.
  assign mem_rd = bus_rd & reset;
  assign mem_we = bus_we & reset;

  // ---------------------------------------------------------------------------
  // Sanity properties.
  // ---------------------------------------------------------------------------
  a_ce_grant_excl : assert property (@(posedge clk) disable iff (!reset)
                                     !(cpu_ce && dma_grant));
  a_ack_in_grant  : assert property (@(posedge clk) disable iff (!reset)
                                     dma_ack |-> dma_grant);

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter (DMA_BURST = 4). A byte-wide synchronous
// memory model sits on the mem_* bus. Every cycle the expected bus outputs are
// pushed to a scoreboard queue when the stimulus is driven and popped/compared
// once the DUT outputs have settled; expected DMA acknowledgements (cycle and
// read data) are queued when a transfer is issued and consumed on dma_ack.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int DMA_BURST = 4;
  localparam int DC        = -1;   // field not compared

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rd;
  logic        cpu_wr_n;
  logic        cpu_ce;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        dma_grant;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  bus_arbiter #(.DMA_BURST(DMA_BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_odata (cpu_odata),
    .cpu_rd    (cpu_rd),
    .cpu_wr_n  (cpu_wr_n),
    .cpu_ce    (cpu_ce),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .dma_grant (dma_grant),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Memory model: synchronous read, garbage when not reading so a held
  // dma_rdata cannot be confused with live memory data.
  logic [7:0] mem [0:65535];
  int we_count  = 0;
  int ack_count = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count      <= we_count + 1;
    end
    mem_rdata <= mem_rd ? mem[mem_addr] : 8'hEE;
    if (dma_ack) ack_count <= ack_count + 1;
  end

  // Scoreboards.
  typedef struct {
    string tag;
    int    ce, gr, ack, rd, we, addr, wd, rdat;
  } cyc_exp_t;

  typedef struct {
    int cyc;
    int rdat;
  } ack_exp_t;

  cyc_exp_t exp_q[$];
  ack_exp_t ack_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rd_hold  = 0;     // expected dma_rdata holding value

  task automatic check(input string tag, input int got, input int exp);
    if (exp < 0) return;
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to the next cycle, 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_ack(input int at_cyc, input int rdat);
    ack_exp_t a;
    a.cyc  = at_cyc;
    a.rdat = rdat;
    ack_q.push_back(a);
  endtask

  // Queue this cycle's expectation, let the inputs settle, then compare.
  task automatic expect_cyc(input string tag, input int ce, input int gr,
                            input int ack, input int rd, input int we,
                            input int addr, input int wd, input int rdat);
    cyc_exp_t e;
    ack_exp_t a;
    e.tag = tag; e.ce = ce; e.gr = gr; e.ack = ack; e.rd = rd; e.we = we;
    e.addr = addr; e.wd = wd; e.rdat = rdat;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".cpu_ce"},    int'(cpu_ce),    e.ce);
    check({e.tag, ".dma_grant"}, int'(dma_grant), e.gr);
    check({e.tag, ".dma_ack"},   int'(dma_ack),   e.ack);
    check({e.tag, ".mem_rd"},    int'(mem_rd),    e.rd);
    check({e.tag, ".mem_we"},    int'(mem_we),    e.we);
    check({e.tag, ".mem_addr"},  int'(mem_addr),  e.addr);
    check({e.tag, ".mem_wdata"}, int'(mem_wdata), e.wd);
    check({e.tag, ".dma_rdata"}, int'(dma_rdata), e.rdat);
    if (dma_ack === 1'b1) begin
      check({e.tag, ".ack_pending"}, int'(ack_q.size() > 0), 1);
      if (ack_q.size() > 0) begin
        a = ack_q.pop_front();
        check({e.tag, ".ack_cycle"}, cyc, a.cyc);
        check({e.tag, ".ack_rdata"}, int'(dma_rdata), a.rdat);
      end
    end
  endtask

  task automatic cpu_a(input string tag);
    expect_cyc(tag, 0, 0, 0, 0, 0, int'(cpu_addr), DC, rd_hold);
  endtask

  task automatic cpu_b(input string tag);
    expect_cyc(tag, 1, 0, 0, 0, 0, int'(cpu_addr), DC, rd_hold);
  endtask

  // One DMA transfer (ACC, DONE, WAIT), entered from the cycle before ACC.
  task automatic xfer(input string tag, input logic we, input int addr,
                      input int wd, input int rd_exp, input logic drop,
                      input logic [15:0] nx_addr, input logic [7:0] nx_wd);
    next_cycle();
    expect_ack(cyc + 1, we ? rd_hold : rd_exp);
    expect_cyc({tag, ".acc"}, 0, 1, 0, we ? 0 : 1, we ? 1 : 0, addr,
               we ? wd : DC, rd_hold);
    next_cycle();
    if (drop) dma_req = 1'b0;
    if (!we) rd_hold = rd_exp;
    expect_cyc({tag, ".done"}, 0, 1, 1, 0, 0, addr, DC, rd_hold);
    next_cycle();
    dma_addr  = nx_addr;
    dma_wdata = nx_wd;
    expect_cyc({tag, ".wait"}, 0, 0, 0, 0, 0, int'(cpu_addr), DC, rd_hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, a0;

    reset = 1'b0; cpu_addr = 16'h0000; cpu_odata = 8'h00; cpu_rd = 1'b0;
    cpu_wr_n = 1'b1; dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000;
    dma_wdata = 8'h00;

    // Reset: strobes stay low even with the CPU asserting both.
    next_cycle();
    cpu_rd = 1'b1; cpu_wr_n = 1'b0; cpu_addr = 16'hBEEF; cpu_odata = 8'h11;
    expect_cyc("reset", 0, 0, 0, 0, 0, 'hBEEF, 'h11, 0);
    cpu_rd = 1'b0; cpu_wr_n = 1'b1; cpu_addr = 16'h0000;
    reset = 1'b1;
    cpu_a("rel");

    // No DMA: cpu_ce alternates, one CPU write lands once in a ce=0 cycle.
    w0 = we_count;
    for (int i = 1; i < 20; i++) begin
      next_cycle();
      cpu_wr_n  = !(i == 4 || i == 5);
      cpu_addr  = (i == 4 || i == 5) ? 16'h0010 : 16'h0000;
      cpu_odata = 8'h3C;
      expect_cyc("nodma", (i % 2 == 1) ? 1 : 0, 0, 0, 0, (i == 4) ? 1 : 0,
                 int'(cpu_addr), (i == 4) ? 'h3C : DC, rd_hold);
    end
    check("nodma.writes", we_count - w0, 1);
    check("nodma.mem10", int'(mem[16'h0010]), 'h3C);

    // DMA write of 0xA5 to 0x0100, requested in CPU_A.
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0100; dma_wdata = 8'hA5;
    cpu_a("dw.a");
    next_cycle(); cpu_b("dw.b");
    xfer("dw", 1'b1, 'h0100, 'hA5, DC, 1'b1, 16'h0100, 8'hA5);
    next_cycle(); cpu_a("dw.a2");
    next_cycle(); cpu_b("dw.b2");
    check("dw.mem100", int'(mem[16'h0100]), 'hA5);

    // DMA read of 0x0100; data held after the ack.
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b0;
    cpu_a("rd.a");
    next_cycle(); cpu_b("rd.b");
    xfer("rd", 1'b0, 'h0100, DC, 'hA5, 1'b1, 16'h0100, 8'h00);
    next_cycle(); cpu_a("rd.hold_a");
    next_cycle(); cpu_b("rd.hold_b");

    // Held request: 4 transfers, one CPU slot, 4 more transfers.
    a0 = ack_count;
    next_cycle();
    cpu_addr = 16'h1234;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'h00;
    cpu_a("bu.a");
    for (int r = 0; r < 2; r++) begin
      if (r > 0) begin
        next_cycle(); cpu_a("bu.forced_a");
      end
      next_cycle(); cpu_b("bu.b");
      for (int k = 0; k < DMA_BURST; k++) begin
        int n;
        n = r * DMA_BURST + k;
        xfer("bu", 1'b1, 'h0200 + n, n, DC, n == 2 * DMA_BURST - 1,
             16'h0200 + 16'(n + 1), 8'(n + 1));
      end
    end
    next_cycle(); cpu_a("bu.end_a");
    next_cycle(); cpu_b("bu.end_b");
    check("bu.acks", ack_count - a0, 2 * DMA_BURST);
    check("bu.mem207", int'(mem[16'h0207]), 'h07);

    // Request arriving in CPU_B of a CPU write slot.
    next_cycle();
    w0 = we_count;
    cpu_addr = 16'h0020; cpu_odata = 8'h5A; cpu_wr_n = 1'b0;
    expect_cyc("mid.a", 0, 0, 0, 0, 1, 'h0020, 'h5A, rd_hold);
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h1FFF; dma_wdata = 8'h77;
    expect_cyc("mid.b", 1, 0, 0, 0, 0, 'h0020, DC, rd_hold);
    // The CPU advances on this cpu_ce: its write cycle is over.
    cpu_wr_n = 1'b1; cpu_addr = 16'h0021;
    xfer("mid", 1'b1, 'h1FFF, 'h77, DC, 1'b1, 16'h1FFF, 8'h77);
    next_cycle(); cpu_a("mid.a2");
    next_cycle(); cpu_b("mid.b2");
    check("mid.writes", we_count - w0, 2);
    check("mid.mem20", int'(mem[16'h0020]), 'h5A);
    check("mid.mem1fff", int'(mem[16'h1FFF]), 'h77);

    // Reset asserted during DMA_ACC: transfer lost, no ack.
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'h99;
    cpu_a("rst.a");
    next_cycle(); cpu_b("rst.b");
    next_cycle();
    w0 = we_count; a0 = ack_count;
    expect_cyc("rst.acc", 0, 1, 0, 0, 1, 'h0300, 'h99, rd_hold);
    reset = 1'b0;
    rd_hold = 0;
    expect_cyc("rst.now", 0, 0, 0, 0, 0, int'(cpu_addr), DC, 0);
    next_cycle();
    dma_req = 1'b0;
    expect_cyc("rst.hold", 0, 0, 0, 0, 0, int'(cpu_addr), DC, 0);
    next_cycle();
    reset = 1'b1;
    cpu_a("rst.rel_a");
    next_cycle(); cpu_b("rst.rel_b");
    next_cycle(); cpu_a("rst.a2");
    check("rst.writes", we_count - w0, 0);
    check("rst.acks", ack_count - a0, 0);
    check("end.ack_queue", ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequencer and two-way arbiter for the Altair synchronous memory bus. It replaces the free-running CPU clock-enable toggle and generates `cpu_ce` itself. Between CPU bus slots it grants the memory bus to a DMA-style loader/debug port, so RAM/ROM can be examined or deposited while the i8080 is frozen. It sits between the CPU, the top-level address decode and the memory mux.

## Interface
- `DMA_BURST`, default 4: maximum consecutive DMA transfers before one CPU slot is forced; legal values ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `cpu_addr`  in  16  CPU address.
- `cpu_odata`  in  8  CPU write data.
- `cpu_rd`  in  1  CPU read strobe.
- `cpu_wr_n`  in  1  CPU write strobe, active-low.
- `cpu_ce`  out  1  CPU clock enable.
- `dma_req`  in  1  DMA request level.
- `dma_we`  in  1  1 = write, 0 = read.
- `dma_addr`  in  16  DMA address.
- `dma_wdata`  in  8  DMA write data.
- `dma_ack`  out  1  one-cycle transfer-complete pulse.
- `dma_rdata`  out  8  read data, valid from the `dma_ack` cycle and held until the next read completes.
- `dma_grant`  out  1  DMA owns the bus; the top level forces the memory (not I/O) decode while high.
- `mem_addr`  out  16  bus address to decode and memories.
- `mem_wdata`  out  8  bus write data.
- `mem_rd`  out  1  bus read strobe.
- `mem_we`  out  1  bus write strobe.
- `mem_rdata`  in  8  decoded read data; synchronous, valid one cycle after `mem_rd`.

## Operation
- States: CPU_A, CPU_B, DMA_ACC, DMA_DONE, DMA_WAIT.
- Burst counter `bcnt` is `$clog2(DMA_BURST+1)` bits wide.
- CPU_A: CPU drives the bus.
  - `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_odata`, `mem_rd`=`cpu_rd`, `mem_we`=~`cpu_wr_n`.
  - `cpu_ce`=0.
  - Next state: CPU_B.
- CPU_B: CPU drives the bus.
  - `mem_addr`/`mem_wdata`/`mem_rd` as in CPU_A; `mem_we`=0, so each CPU write lands exactly once.
  - `cpu_ce`=1.
  - `bcnt`←0.
  - Next state: DMA_ACC if `dma_req`, else CPU_A.
- DMA_ACC: DMA drives the bus.
  - `mem_addr`=`dma_addr`, `mem_wdata`=`dma_wdata`, `mem_we`=`dma_we`, `mem_rd`=~`dma_we`.
  - `dma_grant`=1, `cpu_ce`=0.
  - Next state: DMA_DONE.
- DMA_DONE: `mem_addr` still = `dma_addr`; `mem_rd`=`mem_we`=0; `dma_grant`=1.
  - `dma_ack`=1.
  - For a read, `dma_rdata` is updated from `mem_rdata` so that it is valid in this cycle.
  - `bcnt`←`bcnt`+1.
  - Next state: DMA_WAIT.
- DMA_WAIT: `dma_grant`=0; `mem_*` follow the CPU with `mem_rd`=`mem_we`=0.
  - Next state: DMA_ACC if `dma_req` and `bcnt`<`DMA_BURST`, else CPU_A.
- Arbitration happens only at the end of CPU_B and of DMA_WAIT. A CPU slot (CPU_A→CPU_B) is never split.
- Requester rules:
  - Hold `dma_req`, `dma_addr`, `dma_we` and `dma_wdata` stable from request until the cycle in which `dma_ack`=1.
  - After `dma_ack`, drop `dma_req` or present the next transfer. `dma_req` is not sampled in DMA_DONE.
- The CPU is frozen (`cpu_ce`=0) throughout DMA_ACC/DMA_DONE/DMA_WAIT. `cpu_addr` is stable, so CPU_A re-presents the same cycle.
- Starvation bound: with `dma_req` held high, the CPU gets one 2-cycle slot after every `DMA_BURST` transfers.

## Timing
- Reset (asynchronous, immediate while `reset`=0):
  - State←CPU_A, `bcnt`←0, `dma_rdata`←0.
  - `cpu_ce`=0, `dma_ack`=0, `dma_grant`=0, `mem_rd`=`mem_we`=0.
  - `mem_addr`/`mem_wdata` follow the CPU.
- After reset release, the first `cpu_ce`=1 occurs in the 2nd cycle.
- `cpu_ce` and `dma_grant` are decoded from the state register only; they are glitch-free.
- DMA latency:
  - From `dma_req` high in CPU_A: DMA_ACC 2 cycles later, `dma_ack` 3 cycles later.
  - From `dma_req` high in CPU_B: DMA_ACC next cycle.
- One DMA transfer occupies 3 cycles; back-to-back throughput is 1 transfer per 3 cycles.
- Reset mid-transfer: no `dma_ack` is issued and the transfer is lost. The requester must re-issue it.

## Test plan
- No DMA, 20 cycles after reset release:
  - `cpu_ce` = 0,1,0,1…
  - CPU write to 0x0010: `mem_we` high for exactly one cycle, in a `cpu_ce`=0 cycle.
- DMA write of 0xA5 to 0x0100, requested in CPU_A:
  - `dma_grant` rises 2 cycles later.
  - `mem_we`=1 for one cycle with `mem_addr`=0x0100 and `mem_wdata`=0xA5.
  - `dma_ack` one cycle after that.
  - `cpu_ce`=0 throughout.
- DMA read of 0x0100 with a memory model holding 0xA5: `dma_rdata`=0xA5 in the `dma_ack` cycle and held afterwards.
- `dma_req` held high, `DMA_BURST`=4: exactly 4 acks, then one `cpu_ce` pulse, repeating; `mem_addr` in CPU_A matches the held `cpu_addr`.
- Request arriving mid CPU slot: the CPU write completes once; the DMA write to 0x1FFF happens after CPU_B with no duplicate `mem_we`.
- `reset`=0 asserted during DMA_ACC:
  - `mem_we`, `dma_grant` and `cpu_ce` go to 0 immediately; no `dma_ack`.
  - After release, the state is CPU_A and `dma_rdata`=0.
